instr_encoder: RTL and testbench

Instruction encoder for the RV32I core's toolchain-facing side: accepts decoded instruction fields plus a full 32-bit immediate value and packs them into a legal 32-bit instruction word. It does the inverse of the core's immediate decoding: for every legal input, decoding the immediate of `out_instr` returns `in_imm`. It also expands the `li` pseudo-op into a LUI+ADDI pair. It feeds the self-test program generator and the debug-module instruction injector over a valid/ready stream.

---
 rtl/instr_encoder_pkg.sv | 31 +++
 rtl/instr_encoder_imm_pack.sv | 61 ++++++
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I opcode constants, immediate range limits and encoder state type.
package instr_encoder_pkg;

    localparam logic [6:0] OPC_I_ARITH = 7'b0010011;
    localparam logic [6:0] OPC_I_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_I_JUMP  = 7'b1100111;
    localparam logic [6:0] OPC_S       = 7'b0100011;
    localparam logic [6:0] OPC_B       = 7'b1100011;
    localparam logic [6:0] OPC_U_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_U_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_J       = 7'b1101111;

    localparam logic [2:0] FUNCT3_ADDI = 3'b000;
    localparam logic [2:0] FUNCT3_SLLI = 3'b001;
    localparam logic [2:0] FUNCT3_SRXI = 3'b101;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMMB_MIN  = -4096;
    localparam int IMMB_MAX  = 4094;
    localparam int IMMJ_MIN  = -(1 << 20);
    localparam int IMMJ_MAX  = (1 << 20) - 2;

    typedef enum logic [0:0] {StIdle, StSecond} state_e;

    // Signed inclusive range test on a 32-bit immediate.
    function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: places register fields and immediate bits into one RV32I word
// and flags immediates that the chosen format cannot represent.
module imm_pack
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic is_shift;
    assign is_shift = (funct3_i == FUNCT3_SLLI) || (funct3_i == FUNCT3_SRXI);

    always_comb begin
        instr_o = '1;
        err_o   = 1'b1;
        case (opcode_i)
            OPC_I_ARITH: begin
                if (is_shift) begin
                    instr_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
                    err_o   = |imm_i[31:5];
                end else begin
                    instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                    err_o   = !in_range(imm_i, IMM12_MIN, IMM12_MAX);
                end
            end
            OPC_I_LOAD, OPC_I_JUMP: begin
                instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                err_o   = !in_range(imm_i, IMM12_MIN, IMM12_MAX);
            end
            OPC_S: begin
                instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                err_o   = !in_range(imm_i, IMM12_MIN, IMM12_MAX);
            end
            OPC_B: begin
                instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                           imm_i[4:1], imm_i[11], opcode_i};
                err_o   = imm_i[0] || !in_range(imm_i, IMMB_MIN, IMMB_MAX);
            end
            OPC_J: begin
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                err_o   = imm_i[0] || !in_range(imm_i, IMMJ_MIN, IMMJ_MAX);
            end
            OPC_U_LUI, OPC_U_AUIPC: begin
                instr_o = {imm_i[31:12], rd_i, opcode_i};
                err_o   = |imm_i[11:0];
            end
            default: begin
                instr_o = '1;
                err_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with li expansion; registered valid/ready output stage.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic        in_li,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_err_q, out_err_d;
    logic [4:0]  li_rd_q, li_rd_d;
    logic [11:0] li_lo_q, li_lo_d;

    logic [6:0]  p_opcode;
    logic [4:0]  p_rd, p_rs1, p_rs2;
    logic [2:0]  p_funct3;
    logic [6:0]  p_funct7;
    logic [31:0] p_imm;
    logic [31:0] p_instr;
    logic        p_err;

    logic        li_small, li_two;
    logic [19:0] li_hi;
    logic        accept, fire;

    // (imm + 0x800) >> 12 == imm[31:12] + imm[11], modulo 2^20.
    assign li_hi    = in_imm[31:12] + {19'b0, in_imm[11]};
    assign li_small = in_range(in_imm, IMM12_MIN, IMM12_MAX);
    assign li_two   = !li_small && (|in_imm[11:0]);

    assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid_q && out_ready;

    always_comb begin
        p_opcode = in_opcode;
        p_rd     = in_rd;
        p_rs1    = in_rs1;
        p_rs2    = in_rs2;
        p_funct3 = in_funct3;
        p_funct7 = in_funct7;
        p_imm    = in_imm;
        if (state_q == StSecond) begin
            p_opcode = OPC_I_ARITH;
            p_rd     = li_rd_q;
            p_rs1    = li_rd_q;
            p_funct3 = FUNCT3_ADDI;
            p_imm    = {{20{li_lo_q[11]}}, li_lo_q};
        end else if (in_li) begin
            p_funct3 = FUNCT3_ADDI;
            if (li_small) begin
                p_opcode = OPC_I_ARITH;
                p_rs1    = '0;
            end else begin
                p_opcode = OPC_U_LUI;
                p_imm    = {li_hi, 12'h000};
            end
        end
    end

    imm_pack u_imm_pack (
        .opcode_i (p_opcode),
        .rd_i     (p_rd),
        .rs1_i    (p_rs1),
        .rs2_i    (p_rs2),
        .funct3_i (p_funct3),
        .funct7_i (p_funct7),
        .imm_i    (p_imm),
        .instr_o  (p_instr),
        .err_o    (p_err)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        li_rd_d     = li_rd_q;
        li_lo_d     = li_lo_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_instr_d = p_instr;
                    out_err_d   = !in_li && p_err;
                    if (in_li && li_two) begin
                        state_d = StSecond;
                        li_rd_d = in_rd;
                        li_lo_d = in_imm[11:0];
                    end
                end else if (fire) begin
                    out_valid_d = 1'b0;
                end
            end
            StSecond: begin
                // LUI word leaves this cycle; the ADDI word replaces it directly.
                if (fire) begin
                    out_valid_d = 1'b1;
                    out_instr_d = p_instr;
                    out_err_d   = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
            li_rd_q     <= '0;
            li_lo_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            li_rd_q     <= li_rd_d;
            li_lo_q     <= li_lo_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed vectors, backpressure, random stream, reset mid-li.
module tb_instr_encoder;

    localparam logic [6:0] T_ARITH = 7'b0010011;
    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_JALR  = 7'b1100111;
    localparam logic [6:0] T_S     = 7'b0100011;
    localparam logic [6:0] T_B     = 7'b1100011;
    localparam logic [6:0] T_LUI   = 7'b0110111;
    localparam logic [6:0] T_AUIPC = 7'b0010111;
    localparam logic [6:0] T_J     = 7'b1101111;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        bit          chk_dec;
        logic [31:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic        in_li = 1'b0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic        out_err;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    bit   rand_rdy = 1'b0;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_li     (in_li),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit known_op(input logic [6:0] op);
        return op == T_ARITH || op == T_LOAD || op == T_JALR || op == T_S || op == T_B ||
               op == T_LUI || op == T_AUIPC || op == T_J;
    endfunction

    // Immediate decoder as the core sees it; used to confirm the round trip.
    function automatic logic [31:0] dec_imm(input logic [31:0] w);
        case (w[6:0])
            T_ARITH: begin
                if (w[14:12] == 3'b001 || w[14:12] == 3'b101) return {27'b0, w[24:20]};
                return {{20{w[31]}}, w[31:20]};
            end
            T_LOAD, T_JALR: return {{20{w[31]}}, w[31:20]};
            T_S:            return {{20{w[31]}}, w[31:25], w[11:7]};
            T_B:            return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            T_J:            return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            T_LUI, T_AUIPC: return {w[31:12], 12'b0};
            default:        return 32'hdeadbeef;
        endcase
    endfunction

    task automatic model(input logic li, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                         output exp_t e0, output exp_t e1, output int n);
        longint s;
        logic [31:0] hi, lo;
        bit ok;
        s = $signed(imm);
        n = 1;
        ok = 1'b1;
        e0.imm = imm;
        e0.chk_dec = 1'b0;
        e0.err = 1'b0;
        e1 = e0;
        if (li) begin
            if (s >= -2048 && s <= 2047) begin
                e0.instr = {imm[11:0], 5'd0, 3'b000, rd, T_ARITH};
            end else begin
                hi = (imm + 32'h800) >> 12;
                lo = imm - (hi << 12);
                e0.instr = {hi[19:0], rd, T_LUI};
                if (lo != 0) begin
                    n = 2;
                    e1.instr = {lo[11:0], rd, 3'b000, rd, T_ARITH};
                end
            end
        end else begin
            case (op)
                T_ARITH, T_LOAD, T_JALR: begin
                    if (op == T_ARITH && (f3 == 3'b001 || f3 == 3'b101)) begin
                        ok = imm < 32;
                        e0.instr = {f7, imm[4:0], rs1, f3, rd, op};
                    end else begin
                        ok = s >= -2048 && s <= 2047;
                        e0.instr = {imm[11:0], rs1, f3, rd, op};
                    end
                end
                T_S: begin
                    ok = s >= -2048 && s <= 2047;
                    e0.instr = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                end
                T_B: begin
                    ok = s >= -4096 && s <= 4094 && !imm[0];
                    e0.instr = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                end
                T_J: begin
                    ok = s >= -1048576 && s <= 1048574 && !imm[0];
                    e0.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                end
                T_LUI, T_AUIPC: begin
                    ok = (imm % 4096) == 0;
                    e0.instr = {imm[31:12], rd, op};
                end
                default: begin
                    ok = 1'b0;
                    e0.instr = 32'hffffffff;
                end
            endcase
            e0.err = !ok;
            e0.chk_dec = ok;
        end
    endtask

    task automatic send(input logic li, input logic [6:0] op, input logic [4:0] rd, rs1, rs2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm,
                        input bit use_k, input logic [31:0] k0, k1, input logic kerr);
        exp_t e0, e1;
        int n;
        bit got;
        model(li, op, rd, rs1, rs2, f3, f7, imm, e0, e1, n);
        if (use_k) begin
            e0.instr = k0;
            e0.err = kerr;
            e1.instr = k1;
        end
        in_li = li; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
            in_valid = 1'b0;
            return;
        end
        sb.push_back(e0);
        if (n == 2) sb.push_back(e1);
        @(posedge clk);
        #1;
        chk("latency_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
    endtask

    exp_t        mon_e;
    bit          stall_prev = 1'b0;
    logic [31:0] held_instr;
    logic        held_err;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", {31'b0, out_valid}, 32'd1);
                chk("hold_instr", out_instr, held_instr);
                chk("hold_err", {31'b0, out_err}, {31'b0, held_err});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", out_instr, 32'hxxxxxxxx);
                end else begin
                    mon_e = sb.pop_front();
                    chk("instr", out_instr, mon_e.instr);
                    chk("err", {31'b0, out_err}, {31'b0, mon_e.err});
                    if (mon_e.chk_dec) chk("dec_imm", dec_imm(out_instr), mon_e.imm);
                end
            end
            stall_prev = out_valid && !out_ready;
            held_instr = out_instr;
            held_err   = out_err;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic send_random();
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        li;
        int          k;
        k  = $urandom_range(0, 9);
        li = 1'b0;
        f3 = 3'($urandom_range(0, 7));
        f7 = 7'($urandom);
        imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        case (k)
            0: begin
                op = T_ARITH;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    imm = 32'($urandom_range(0, 31));
                    f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
                end
            end
            1: op = T_LOAD;
            2: op = T_JALR;
            3: op = T_S;
            4: begin op = T_B; imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1; end
            5: begin op = T_J; imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1; end
            6: begin op = T_LUI;   imm = $urandom & 32'hfffff000; end
            7: begin op = T_AUIPC; imm = $urandom & 32'hfffff000; end
            8: begin
                op = T_ARITH;
                li = 1'b1;
                case ($urandom_range(0, 2))
                    0: imm = imm;
                    1: imm = $urandom & 32'hfffff000;
                    default: imm = $urandom;
                endcase
            end
            default: begin
                op = 7'($urandom);
                while (known_op(op)) op = 7'($urandom);
            end
        endcase
        if (!li && $urandom_range(0, 7) == 0) imm = $urandom;
        send(li, op, 5'($urandom), 5'($urandom), 5'($urandom), f3, f7, imm,
             1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'b0, out_err}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        send(0, T_ARITH, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1, 32'h00500093, '0, 0);
        send(0, T_B, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4, 1, 32'hFE208EE3, '0, 0);
        send(0, T_B, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, 0, '0, '0, 0);
        send(0, T_J, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048, 1, 32'h001000EF, '0, 0);
        send(0, T_J, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00100000, 0, '0, '0, 1);
        send(1, T_ARITH, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345FFF,
             1, 32'h123462B7, 32'hFFF28293, 0);
        chk("li_in_ready_low", {31'b0, in_ready}, 32'd0);
        send(1, T_ARITH, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00001000, 1, 32'h000012B7, '0, 0);
        send(0, 7'h7F, 5'd3, 5'd4, 5'd5, 3'b010, 7'd0, 32'd0, 1, 32'hFFFFFFFF, '0, 1);
        send(0, T_LUI, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00001001, 0, '0, '0, 0);
        send(0, T_ARITH, 5'd8, 5'd9, 5'd0, 3'b001, 7'd0, 32'd40, 0, '0, '0, 0);

        // Hold the consumer off for 5 cycles with a new input pending.
        send(0, T_S, 5'd0, 5'd6, 5'd7, 3'b010, 7'd0, -32'sd100, 0, '0, '0, 0);
        out_ready = 1'b0;
        fork
            send(0, T_LOAD, 5'd10, 5'd11, 5'd0, 3'b010, 7'd0, 32'd2047, 0, '0, '0, 0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) send_random();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(1, T_ARITH, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345FFF, 0, '0, '0, 0);
        rst_n = 1'b0;
        #1;
        chk("midli_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("midli_rst_instr", out_instr, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(0, T_ARITH, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1, 32'h00500093, '0, 0);

        for (int c = 0; c < 100 && sb.size() != 0; c++) @(posedge clk);
        @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
        chk("final_idle_ready", {31'b0, in_ready}, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
